// File: rtl/exp_e_pkg.sv
// Shared constants for the shift-and-add exponential / logarithm units.
// Q16.16 multiples of ln2 and ln(1+2^-k), plus the saturation threshold.
package exp_e_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_t;

   localparam int INT_STEPS = 4;

   // Arguments at or above 16*ln2 would overflow a 16-bit integer result.
   localparam logic [31:0] SAT_THRESHOLD = 32'h000B_1721;

   // Index 0 is the first step executed: 8*ln2, then 4*ln2, 2*ln2, ln2.
   localparam logic [3:0][31:0] INT_CONST = {
      32'h0000_B172, 32'h0001_62E4, 32'h0002_C5C8, 32'h0005_8B91
   };
   localparam logic [3:0][3:0] INT_SHIFT = {4'd1, 4'd2, 4'd4, 4'd8};

   // Index k-1 holds ln(1+2^-k) for k = 1..7.
   localparam logic [6:0][31:0] FRAC_CONST = {
      32'h0000_01FE, 32'h0000_03F8, 32'h0000_07E1, 32'h0000_0F85,
      32'h0000_1E27, 32'h0000_3920, 32'h0000_67CD
   };

endpackage

// File: rtl/exp_e.sv
// Sequential natural exponential: floor(e^arg) for an unsigned Q16.16 argument,
// one shift-and-add refinement step per clock behind a valid/ready handshake.
module exp_e
   import exp_e_pkg::*;
#(
   parameter int FRAC_STEPS = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_arg,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_result,
   output logic        out_sat
);

   localparam logic [3:0] LAST_STEP = 4'(3 + FRAC_STEPS);

   state_t      state;
   state_t      state_next;
   logic [31:0] y;
   logic [33:0] x;
   logic [3:0]  step;
   logic        sat_pend;

   logic [31:0] cur_const;
   logic [33:0] x_step;
   logic [33:0] x_next;
   logic [31:0] y_next;
   logic [3:0]  frac_k;
   logic [3:0]  frac_idx;
   logic        take;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign frac_k    = step - 4'd3;
   assign frac_idx  = step - 4'd4;

   // Per-step constant and candidate accumulator update, selected by step index.
   always_comb begin
      cur_const = '0;
      x_step    = x;
      if (step < 4'(INT_STEPS)) begin
         cur_const = INT_CONST[step[1:0]];
         x_step    = x << INT_SHIFT[step[1:0]];
      end else begin
         cur_const = FRAC_CONST[frac_idx[2:0]];
         x_step    = x + (x >> frac_k);
      end
      take   = (y >= cur_const);
      y_next = take ? (y - cur_const) : y;
      x_next = take ? x_step : x;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Saturating arguments spend one ITER cycle so both paths report from a registered DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = ITER;
            end
         end
         ITER: begin
            if (sat_pend || (step == LAST_STEP)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y          <= '0;
         x          <= '0;
         step       <= '0;
         sat_pend   <= 1'b0;
         out_result <= '0;
         out_sat    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  step <= '0;
                  if (in_arg >= SAT_THRESHOLD) begin
                     sat_pend <= 1'b1;
                     y        <= '0;
                     x        <= '0;
                  end else begin
                     sat_pend <= 1'b0;
                     y        <= in_arg;
                     x        <= 34'h0_0001_0000;
                  end
               end
            end
            ITER: begin
               if (sat_pend) begin
                  out_result <= 16'hFFFF;
                  out_sat    <= 1'b1;
               end else begin
                  y    <= y_next;
                  x    <= x_next;
                  step <= step + 4'd1;
                  if (step == LAST_STEP) begin
                     // Bits above the integer field only light up on arithmetic overflow.
                     if (x_next[33:32] != 2'b00) begin
                        out_result <= 16'hFFFF;
                        out_sat    <= 1'b1;
                     end else begin
                        out_result <= x_next[31:16];
                        out_sat    <= 1'b0;
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
